// File: rtl/board_pkg.sv
// Shared board definitions for the move controller, display and win-check blocks.
package board_pkg;

  localparam int BOARD_ROWS = 8;
  localparam int BOARD_COLS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DROP   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } move_state_t;

endpackage

// File: rtl/move_ctrl_col_select.sv
// Column-select decoder: flags a one-hot request and encodes the selected column.
module col_select #(
  parameter int COLS = 8
) (
  input  logic [COLS-1:0]         sw_sync,
  output logic                    any,
  output logic                    vld,
  output logic [$clog2(COLS)-1:0] col
);

  always_comb begin
    any = |sw_sync;
    // Clearing the lowest set bit leaves zero only when exactly one bit was set.
    vld = any && ((sw_sync & (sw_sync - COLS'(1))) == '0);
    col = '0;
    for (int i = 0; i < COLS; i++) begin
      if (sw_sync[i]) col = ($clog2(COLS))'(i);
    end
  end

endmodule

// File: rtl/move_ctrl.sv
// Piece-drop controller: accepts a column request, animates the fall one row per
// drop_tick, commits the piece to the current player's array and alternates turns.
module move_ctrl
  import board_pkg::*;
#(
  parameter int COLS = BOARD_COLS,
  parameter int ROWS = BOARD_ROWS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [COLS-1:0]              sw_sync,
  input  logic                         drop_tick,
  output logic [ROWS-1:0][COLS-1:0]    red_array,
  output logic [ROWS-1:0][COLS-1:0]    green_array,
  output logic [$clog2(ROWS)-1:0]      fall_row,
  output logic [$clog2(COLS)-1:0]      fall_col,
  output logic                         player,
  output logic                         busy,
  output logic                         placed,
  output logic                         reject,
  output logic                         board_full
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int HW    = $clog2(ROWS + 1);
  localparam int MW_RQ = $clog2(ROWS * COLS + 1);
  localparam int MW    = (MW_RQ > 7) ? MW_RQ : 7;

  move_state_t     state, state_nxt;
  logic [HW-1:0]   height [COLS];
  logic [MW-1:0]   move_cnt;
  logic [RW-1:0]   target_row;

  logic            sel_any, sel_vld;
  logic [CW-1:0]   sel_col;
  logic            col_full;
  logic            accept, refuse, commit, last_move;

  col_select #(.COLS(COLS)) u_col_select (
    .sw_sync (sw_sync),
    .any     (sel_any),
    .vld     (sel_vld),
    .col     (sel_col)
  );

  assign col_full   = (height[sel_col] == HW'(ROWS));
  assign accept     = (state == ST_IDLE) && sel_vld && !col_full;
  assign refuse     = (state == ST_IDLE) && sel_any && !(sel_vld && !col_full);
  assign commit     = (state == ST_COMMIT);
  assign last_move  = (move_cnt == MW'(ROWS * COLS - 1));
  assign busy       = (state == ST_DROP) || (state == ST_COMMIT);
  assign board_full = (state == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_DROP;
      ST_DROP:   if (drop_tick && (fall_row == target_row)) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = last_move ? ST_DONE : ST_IDLE;
      ST_DONE:   state_nxt = ST_DONE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Landing row only matters between accept and commit, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) target_row <= RW'(ROWS - 1) - RW'(height[sel_col]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red_array   <= '0;
      green_array <= '0;
      height      <= '{default: '0};
      move_cnt    <= '0;
      player      <= 1'b0;
      fall_row    <= '0;
      fall_col    <= '0;
      placed      <= 1'b0;
      reject      <= 1'b0;
    end else begin
      placed <= commit;
      reject <= refuse;
      if (accept) begin
        fall_col <= sel_col;
        fall_row <= '0;
      end
      if ((state == ST_DROP) && drop_tick && (fall_row < target_row))
        fall_row <= fall_row + RW'(1);
      if (commit) begin
        if (player) green_array[target_row][fall_col] <= 1'b1;
        else        red_array[target_row][fall_col]   <= 1'b1;
        height[fall_col] <= height[fall_col] + HW'(1);
        move_cnt         <= move_cnt + MW'(1);
        player           <= ~player;
      end
    end
  end

endmodule

// File: tb/tb_move_ctrl.sv
// Randomized bench for move_ctrl against a cell-level board model.
module tb_move_ctrl;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [COLS-1:0]           sw_sync;
  logic                      drop_tick;
  logic [ROWS-1:0][COLS-1:0] red_array, green_array;
  logic [2:0]                fall_row;
  logic [2:0]                fall_col;
  logic                      player, busy, placed, reject, board_full;

  move_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_sync     (sw_sync),
    .drop_tick   (drop_tick),
    .red_array   (red_array),
    .green_array (green_array),
    .fall_row    (fall_row),
    .fall_col    (fall_col),
    .player      (player),
    .busy        (busy),
    .placed      (placed),
    .reject      (reject),
    .board_full  (board_full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: 0 empty, 1 red, 2 green; pieces stack from the bottom row.
  int cells [ROWS][COLS];
  int m_player;
  int m_moves;
  bit m_done;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int colh(input int c);
    int h = 0;
    for (int r = 0; r < ROWS; r++) if (cells[r][c] != 0) h++;
    return h;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) cells[r][c] = 0;
    m_player = 0;
    m_moves  = 0;
    m_done   = 1'b0;
  endtask

  task automatic chk_board(input string tag);
    logic [ROWS-1:0][COLS-1:0] er, eg;
    er = '0;
    eg = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        er[r][c] = (cells[r][c] == 1);
        eg[r][c] = (cells[r][c] == 2);
      end
    chk({tag, "_red"}, 64'(red_array), 64'(er));
    chk({tag, "_green"}, 64'(green_array), 64'(eg));
    chk({tag, "_disjoint"}, 64'(red_array & green_array), 64'd0);
    chk({tag, "_player"}, 64'(player), 64'(m_player));
  endtask

  task automatic issue(input logic [COLS-1:0] mask, output bit acc, output int col);
    int  n;
    bit  exp_rej;
    n   = $countones(mask);
    col = -1;
    for (int i = 0; i < COLS; i++) if (mask[i]) col = i;
    acc     = !m_done && (n == 1) && (colh(col) < ROWS);
    exp_rej = !m_done && ((n > 1) || ((n == 1) && (colh(col) == ROWS)));
    sw_sync = mask;
    step();
    sw_sync = '0;
    chk("req_reject", 64'(reject), 64'(exp_rej));
    chk("req_busy", 64'(busy), 64'(acc));
    chk("req_full", 64'(board_full), 64'(m_done));
    if (acc) begin
      chk("req_col", 64'(fall_col), 64'(col));
      chk("req_row0", 64'(fall_row), 64'd0);
    end else begin
      step();
      chk("reject_clear", 64'(reject), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk_board("refused");
    end
  endtask

  task automatic drop(input int col);
    int tgt;
    tgt = ROWS - 1 - colh(col);
    for (int k = 0; k <= tgt; k++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        sw_sync = ($urandom_range(0, 1) == 1) ? COLS'($urandom) : '0;
        step();
        sw_sync = '0;
        chk("drop_hold_row", 64'(fall_row), 64'(k));
        chk("drop_no_reject", 64'(reject), 64'd0);
      end
      drop_tick = 1'b1;
      step();
      drop_tick = 1'b0;
      chk("drop_busy", 64'(busy), 64'd1);
      chk("drop_no_placed", 64'(placed), 64'd0);
      if (k < tgt) chk("drop_row", 64'(fall_row), 64'(k + 1));
    end
    step();
    cells[tgt][col] = m_player + 1;
    m_player ^= 1;
    m_moves++;
    if (m_moves == ROWS * COLS) m_done = 1'b1;
    chk("commit_placed", 64'(placed), 64'd1);
    chk("commit_busy", 64'(busy), 64'd0);
    chk("commit_full", 64'(board_full), 64'(m_done));
    chk_board("commit");
    step();
    chk("placed_clear", 64'(placed), 64'd0);
  endtask

  task automatic play(input int col);
    bit acc;
    int c;
    issue(COLS'(1) << col, acc, c);
    if (acc) drop(c);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_red", 64'(red_array), 64'd0);
    chk("rst_green", 64'(green_array), 64'd0);
    chk("rst_outs", 64'({fall_row, fall_col, player, busy, placed, reject, board_full}), 64'd0);
    step();
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int c;
    sw_sync   = '0;
    drop_tick = 1'b0;
    model_clear();
    do_reset();
    step();

    play(2);
    chk("first_red72", 64'(red_array[7][2]), 64'd1);
    play(2);
    chk("second_green62", 64'(green_array[6][2]), 64'd1);

    issue(8'h06, acc, c);

    for (int i = 0; i < ROWS; i++) play(0);
    issue(8'h01, acc, c);

    for (int i = 0; i < 30; i++) begin
      logic [COLS-1:0] m;
      case ($urandom_range(0, 3))
        0: m = '0;
        1: m = COLS'($urandom) | 8'h81;
        default: m = COLS'(1) << $urandom_range(0, COLS - 1);
      endcase
      if (m == '0) begin
        step();
        chk("zero_reject", 64'(reject), 64'd0);
        chk("zero_busy", 64'(busy), 64'd0);
      end else begin
        issue(m, acc, c);
        if (acc) drop(c);
      end
    end

    do_reset();
    issue(8'h08, acc, c);
    for (int k = 0; k < 3; k++) begin
      drop_tick = 1'b1;
      step();
      drop_tick = 1'b0;
    end
    chk("mid_row3", 64'(fall_row), 64'd3);
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drop_tick = 1'b1;
      step();
      drop_tick = 1'b0;
      chk("abort_placed", 64'(placed), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
    end
    chk_board("abort");

    while (m_moves < ROWS * COLS) begin
      c = $urandom_range(0, COLS - 1);
      while (colh(c) == ROWS) c = (c + 1) % COLS;
      if ($urandom_range(0, 7) == 0) issue(8'hC0, acc, c);
      else play(c);
    end
    chk("full_flag", 64'(board_full), 64'd1);
    issue(8'h01, acc, c);
    issue(8'h30, acc, c);
    chk("done_stays", 64'(board_full), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
